// File: rtl/jtopl_lfo_gen.sv
// jtopl_lfo_gen: OPL-family LFO producing the vibrato phase index and a
// triangular tremolo level, with selectable AM depth and synchronous clear.
module jtopl_lfo_gen #(
  parameter int NSLOT        = 18,
  parameter int CNTW         = 13,
  parameter int AM_STEP_BITS = 6,
  parameter int AMW          = 7,
  parameter int AM_MAX       = 105
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cenop,
  input  logic [NSLOT-1:0] slot,
  input  logic             am_dp,
  input  logic             lfo_clr,
  output logic [2:0]       vib_cnt,
  output logic [AMW-3:0]   trem
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [AMW-1:0] AM_PEAK = AMW'(AM_MAX);

  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [AMW-1:0]  am_q, am_d, am_plus, am_minus;
  dir_e            dir_q, dir_d;
  logic            step_q, step_d;
  logic [AMW-3:0]  trem_q, trem_d;
  logic            boundary, am_ev;

  // Only the first and last slot bits matter; the rest are positional filler.
  logic unused_slot;
  assign unused_slot = ^slot;

  assign boundary = cenop & slot[NSLOT-1];
  assign am_ev    = cenop & slot[0];
  assign cnt_inc  = cnt_q + CNTW'(1);
  assign am_plus  = am_q + AMW'(1);
  assign am_minus = am_q - AMW'(1);

  // Next-state: clear has priority; AM event evaluated before the sample
  // boundary so a coincident boundary's am_step value overrides the clear.
  always_comb begin
    cnt_d  = cnt_q;
    am_d   = am_q;
    dir_d  = dir_q;
    step_d = step_q;
    trem_d = trem_q;
    if (lfo_clr) begin
      cnt_d  = '0;
      am_d   = '0;
      dir_d  = DIR_UP;
      step_d = 1'b0;
    end else begin
      if (am_ev) begin
        trem_d = am_dp ? am_q[AMW-1:2] : {2'b00, am_q[AMW-1:4]};
        if (step_q) begin
          if (dir_q == DIR_UP) begin
            if (am_q != AM_PEAK) am_d = am_plus;
            if (am_plus == AM_PEAK) dir_d = DIR_DOWN;
          end else begin
            if (am_q != '0) am_d = am_minus;
            if (am_minus == '0) dir_d = DIR_UP;
          end
        end
        step_d = 1'b0;
      end
      if (boundary) begin
        cnt_d  = cnt_inc;
        step_d = &cnt_inc[AM_STEP_BITS-1:0];
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      am_q   <= '0;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
      trem_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      am_q   <= am_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      trem_q <= trem_d;
    end
  end

  assign vib_cnt = cnt_q[CNTW-1:CNTW-3];
  assign trem    = trem_q;

endmodule

// File: tb/tb_jtopl_lfo_gen.sv
// tb_jtopl_lfo_gen: checkpoint table plus hand sequences for clear, hold,
// async reset and coincident first/last slot.
module tb_jtopl_lfo_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cenop = 1'b0;
  logic [1:0] slot = 2'b00;
  logic       am_dp = 1'b1;
  logic       lfo_clr = 1'b0;
  logic [2:0] vib_cnt;
  logic [4:0] trem;

  int checks = 0;
  int errors = 0;
  int samples = 0;

  typedef struct {
    int   n;
    logic dp;
    int   vib;
    int   trem;
  } vec_t;

  typedef struct {
    int vib;
    int trem;
  } exp_t;

  exp_t sb[$];

  jtopl_lfo_gen #(.NSLOT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cenop(cenop), .slot(slot),
    .am_dp(am_dp), .lfo_clr(lfo_clr), .vib_cnt(vib_cnt), .trem(trem)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check1(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int ev, input int et);
    check1({name, ".vib_cnt"}, int'(vib_cnt), ev);
    check1({name, ".trem"}, int'(trem), et);
  endtask

  task automatic cyc(input logic c, input logic [1:0] s);
    cenop = c;
    slot  = s;
    @(posedge clk);
    #1;
  endtask

  // One sample: slot[0] (AM event) then slot[1] (sample boundary).
  task automatic run_to(input int n);
    while (samples < n) begin
      cyc(1'b1, 2'b01);
      cyc(1'b1, 2'b10);
      samples++;
    end
  endtask

  vec_t vecs[10];
  exp_t e;

  initial begin
    // Expected values: after n samples from clear, cnt = n, and trem shows am
    // before the last AM event, where am = triangle(floor((n-1)/64)).
    vecs[0] = '{1,     1'b1, 0, 0};
    vecs[1] = '{1024,  1'b1, 1, 3};   // am 15
    vecs[2] = '{2048,  1'b0, 2, 1};   // am 31 shallow
    vecs[3] = '{6721,  1'b1, 6, 26};  // am 105 peak
    vecs[4] = '{6785,  1'b0, 6, 6};   // am 104 shallow
    vecs[5] = '{7233,  1'b1, 7, 24};  // am 97, descending
    vecs[6] = '{8192,  1'b1, 0, 20};  // vib wraps, am 83
    vecs[7] = '{8193,  1'b1, 0, 20};  // am 82
    vecs[8] = '{13441, 1'b1, 5, 0};   // am 0 bottom
    vecs[9] = '{14721, 1'b1, 6, 5};   // am 20, ascending again

    #2 rst_n = 1'b0;
    #1 check_out("reset", 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_out("post_reset", 0, 0);

    for (int unsigned i = 0; i < 10; i++) begin
      am_dp = vecs[i].dp;
      sb.push_back('{vecs[i].vib, vecs[i].trem});
      run_to(vecs[i].n);
      e = sb.pop_front();
      check_out($sformatf("vec%0d_n%0d", i, vecs[i].n), e.vib, e.trem);
    end

    // Asynchronous reset mid-run, between clock edges.
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    samples = 0;

    // cenop low holds everything regardless of slot activity.
    am_dp = 1'b1;
    run_to(1024);
    check_out("pre_hold", 1, 3);
    for (int unsigned i = 0; i < 1000; i++) cyc(1'b0, 2'(i % 4));
    check_out("hold", 1, 3);
    run_to(2048);
    check_out("after_hold", 2, 7);  // am 31

    // Clear while descending at am 50; trem holds until the next slot[0].
    run_to(10240);
    check_out("pre_clear", 2, 12);  // trem from am 51, am now 50
    lfo_clr = 1'b1;
    cyc(1'b0, 2'b00);
    lfo_clr = 1'b0;
    check_out("clear_hold", 0, 12);
    cyc(1'b1, 2'b01);
    check1("clear_trem0", int'(trem), 0);
    cyc(1'b1, 2'b10);
    samples = 1;
    run_to(1024);
    check_out("clear_dir_up", 1, 3);

    // Coincident first/last slot: boundary's am_step value wins over clear.
    lfo_clr = 1'b1;
    cyc(1'b1, 2'b11);
    lfo_clr = 1'b0;
    check1("clr_priority_vib", int'(vib_cnt), 0);
    for (int unsigned i = 0; i < 1024; i++) cyc(1'b1, 2'b11);
    check_out("simul_slots", 1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtopl_lfo_gen.md
Name: jtopl_lfo_gen

Overview:
Parametrised low-frequency oscillator for the OPL-family operator pipeline. It generates the vibrato phase index and a triangular tremolo (AM) level, and adds selectable AM depth plus a synchronous LFO clear. Counter widths, slot count and AM peak are configurable so OPL/OPLL/OPL3 variants can share one block. It sits beside the slot timer and feeds the phase generator (vib_cnt) and envelope/attenuation stage (trem).

Parameters:
NSLOT, 18, slots per sample cycle; width of one-hot slot bus
CNTW, 13, LFO sample counter width; vib_cnt is its top 3 bits
AM_STEP_BITS, 6, AM steps once every 2^AM_STEP_BITS samples
AMW, 7, AM accumulator width
AM_MAX, 105, AM triangle peak (must be < 2^AMW)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cenop  in  1  operator clock enable; all state updates only when high (except resets)
slot  in  NSLOT  one-hot slot position; bit NSLOT-1 = last slot of sample
am_dp  in  1  AM depth: 1 = deep (am>>2), 0 = shallow (am>>4)
lfo_clr  in  1  synchronous LFO clear (test-register bit)
vib_cnt  out  3  vibrato phase index
trem  out  AMW-2  tremolo attenuation level

Behaviour:
- rst_n low (async, any time): cnt=0, am=0, am_dir=up, am_step=0, trem=0; vib_cnt=0 follows.
- Sample boundary = cenop & slot[NSLOT-1]: cnt <= cnt+1, wraps 2^CNTW-1 -> 0; am_step <= (low AM_STEP_BITS bits of cnt+1 all ones).
- vib_cnt = cnt[CNTW-1:CNTW-3], combinational from register; changes the cycle after each boundary where those bits change.
- AM update at cenop & slot[0], when am_step=1; am_step cleared at that same event.
  - dir up: am <= am+1; if am+1 == AM_MAX, am_dir <= down.
  - dir down: am <= am-1; if am-1 == 0, am_dir <= up.
  - am never exceeds AM_MAX nor goes below 0; no wrap.
- trem registered at every cenop & slot[0] from the pre-update am: am_dp ? am[AMW-1:2] : {2'b00, am[AMW-1:4]}. One AM-step lag from am to trem by design. am_dp changes take effect at next slot[0].
- slot[NSLOT-1] and slot[0] simultaneous (NSLOT=1): both actions apply same cycle; AM uses old am_step; am_step then takes the boundary value (set wins over clear).
- cenop low: all registers hold, including with slot bits active.
- lfo_clr high at a clock edge (cenop ignored): cnt, am, am_step <= 0, am_dir <= up; trem holds until next slot[0]. Priority over boundary/AM updates.
- Period with defaults: AM triangle 2*105*64 = 13440 samples; vib_cnt cycles every 8192 samples.
- Outputs glitch-free: all registered, except vib_cnt, which is a direct slice of registered cnt.

Test Plan:
1. Assert rst_n low mid-run, release -> vib_cnt=0, trem=0 immediately (async); first AM step after 64 sample boundaries gives am=1.
2. Run 1024 sample boundaries (defaults) -> vib_cnt=1; after 8192 boundaries -> vib_cnt wraps to 0.
3. Run 6720 boundaries, am_dp=1 -> am=105, trem=26 at following slot[0]; next AM step gives am=104 (direction reversed).
4. Same point with am_dp=0 -> trem=6; continue to 13440 boundaries -> am=0, dir up, next step am=1.
5. Pulse lfo_clr for one clk with cenop=0 at am=50 -> am=0, cnt=0, dir up; trem keeps old value until next cenop&slot[0], then 0.
6. Hold cenop=0 for 1000 clks with slot toggling -> cnt, am, trem, vib_cnt unchanged.
